// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI controller.
//   spi_state_e : controller FSM states
//   SPI_CPOL / SPI_CPHA : clock polarity/phase this controller implements
//   SPI_BYTE_W : default transfer width
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  localparam logic SPI_CPOL   = 1'b0;
  localparam logic SPI_CPHA   = 1'b0;
  localparam int   SPI_BYTE_W = 8;

endpackage

// File: rtl/spi_sck_tick.sv
// Half-period timer for the SPI clock.
//   m_clk   : system clock
//   rst_n   : synchronous active-low reset
//   restart : holds the counter at 0; counting starts the cycle after it drops
//   tick    : one-cycle pulse every CLK_DIV cycles while not restarted
module spi_sck_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic m_clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge m_clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Pulses in the last cycle of each half-period, so the edge it enables
  // lands exactly CLK_DIV cycles after the previous one.
  assign tick = !restart && (cnt_q == LAST);

endmodule

// File: rtl/spi_controller_mode0.sv
// Byte-oriented SPI controller, mode 0 (CPOL=0, CPHA=0), MSB first.
//   m_clk, rst_n          : clock, synchronous active-low reset
//   start, tx_data, hold_cs : transfer request; data and hold flag captured on accept
//   cs_release            : drops a held CSn while idle
//   busy                  : transfer or CSn gap in progress
//   rx_valid, rx_data     : received byte, rx_valid pulses for one cycle
//   sck_pad, mosi_pad, csn_pad, miso_pad : SPI pins
//   state_dbg             : current FSM state
//
// Handshake: a request is accepted in any cycle where start=1 and busy=0;
// tx_data and hold_cs are captured in that cycle and busy is 1 from the next
// cycle until the transfer (and any CSn gap) is finished. start while busy=1
// is dropped, never queued.
module spi_controller_mode0
  import spi_pkg::*;
#(
  parameter int BYTE_W  = SPI_BYTE_W,
  parameter int CLK_DIV = 4
) (
  input  logic              m_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              hold_cs,
  input  logic              cs_release,
  output logic              busy,
  output logic              rx_valid,
  output logic [BYTE_W-1:0] rx_data,
  output logic              sck_pad,
  output logic              mosi_pad,
  output logic              csn_pad,
  input  logic              miso_pad,
  output spi_state_e        state_dbg
);

  localparam int CNT_W = $clog2(BYTE_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  spi_state_e        state_q, state_d;
  logic              tick;
  logic              cs_low_q;
  logic              sck_q;
  logic              hold_q;
  logic [BYTE_W-1:0] tx_sr_q;
  logic [BYTE_W-1:0] rx_sr_q;
  logic [BYTE_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic [CNT_W-1:0]  bit_cnt_q;

  // FSM strobes
  logic accept, release_cs, drop_cs, rise, fall, last_fall;

  // The timer only runs outside IDLE, so every non-idle state begins a
  // fresh half-period on the cycle after leaving IDLE.
  spi_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .m_clk   (m_clk),
    .rst_n   (rst_n),
    .restart (state_q == IDLE),
    .tick    (tick)
  );

  always_ff @(posedge m_clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    release_cs = 1'b0;
    drop_cs    = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    last_fall  = 1'b0;
    case (state_q)
      IDLE: begin
        // start has priority; a simultaneous cs_release is dropped.
        if (start) begin
          accept  = 1'b1;
          state_d = SETUP;
        end else if (cs_release && cs_low_q) begin
          release_cs = 1'b1;
          state_d    = GAP;
        end
      end
      SETUP: begin
        if (tick) begin
          rise    = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          if (sck_q) begin
            fall = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              last_fall = 1'b1;
              state_d   = TRAIL;
            end
          end else begin
            rise = 1'b1;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          if (hold_q) begin
            state_d = IDLE;
          end else begin
            drop_cs = 1'b1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_clk) begin
    if (!rst_n) begin
      cs_low_q   <= 1'b0;
      sck_q      <= SPI_CPOL;
      hold_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      if (accept) begin
        cs_low_q  <= 1'b1;
        tx_sr_q   <= tx_data;
        hold_q    <= hold_cs;
        bit_cnt_q <= '0;
      end
      if (release_cs || drop_cs) cs_low_q <= 1'b0;
      if (rise) begin
        sck_q   <= 1'b1;
        rx_sr_q <= {rx_sr_q[BYTE_W-2:0], miso_pad};
      end
      if (fall) begin
        sck_q     <= 1'b0;
        tx_sr_q   <= {tx_sr_q[BYTE_W-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      // The last bit was shifted in on the preceding rising edge, so rx_sr
      // is complete by the final falling edge.
      if (last_fall) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= rx_sr_q;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign sck_pad   = sck_q;
  assign csn_pad   = !cs_low_q;
  assign mosi_pad  = cs_low_q & tx_sr_q[BYTE_W-1];
  assign state_dbg = state_q;

endmodule

// File: doc/spi_controller_mode0.md
# spi_controller_mode0

Byte-oriented SPI controller (master) for SPI mode 0 (CPOL=0, CPHA=0), MSB first, clocked from the fabric clock. It generates SCK, CSn and MOSI toward an external or on-chip SPI peripheral and samples MISO. It exposes a start/busy/done handshake to local logic and can hold CSn low across consecutive bytes for multi-byte frames.

## Interface
Parameters:
- BYTE_W, 8, bits per transfer.
- CLK_DIV, 4, SCK half-period in m_clk cycles. Legal range is 2 or more; SCK frequency is f(m_clk)/(2*CLK_DIV).

Ports:
- m_clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request one transfer; accepted only when busy=0.
- tx_data  in  BYTE_W  byte to send; captured in the same cycle start is accepted.
- hold_cs  in  1  captured with start; 1 keeps CSn low after the byte.
- cs_release  in  1  one-cycle pulse; deasserts a held CSn while idle.
- busy  out  1  transfer or CSn gap in progress.
- rx_valid  out  1  one-cycle pulse; rx_data is valid in that cycle.
- rx_data  out  BYTE_W  received byte; holds its value until the next rx_valid.
- sck_pad  out  1  SPI clock; idles at 0.
- mosi_pad  out  1  serial data out; driven 0 while CSn is high.
- csn_pad  out  1  chip select, active low.
- miso_pad  in  1  serial data in; sampled directly, with no synchronizer.

## Operation
- States:
  - IDLE: CSn high or held low, SCK=0.
  - SETUP: CSn low, MOSI holds the MSB, wait CLK_DIV cycles.
  - XFER: 2*BYTE_W SCK half-periods.
  - TRAIL: wait CLK_DIV cycles after the last falling edge.
  - GAP: CSn high for CLK_DIV cycles.
- Transitions:
  - IDLE to SETUP on start.
  - SETUP to XFER when the half-period counter expires.
  - XFER to TRAIL after the BYTE_W-th falling edge.
  - TRAIL to IDLE if hold_cs was captured (CSn stays low). Otherwise TRAIL to GAP.
  - GAP to IDLE.
  - IDLE with CSn held low to GAP on cs_release.
- Shift registers:
  - A start with CSn already held low still passes through SETUP.
  - On every SCK rising edge: rx_sr <= {rx_sr[BYTE_W-2:0], miso_pad}.
  - On every SCK falling edge: tx_sr shifts left and fills with 0.
  - mosi_pad = tx_sr[BYTE_W-1] while CSn is low.
- Bit counter: log2(BYTE_W)+1 bits wide, counting falling edges. The half-period counter is clog2(CLK_DIV) bits wide and wraps to 0 on expiry.
- Boundary conditions:
  - start while busy=1: ignored, with no queueing.
  - start and cs_release in the same cycle in IDLE: start wins and cs_release is dropped.
  - cs_release while CSn is already high, or while busy=1: ignored.
  - rst_n=0 at any point, including mid-byte: on the next edge sck_pad=0, csn_pad=1, mosi_pad=0, busy=0, rx_valid=0, rx_data=0, state IDLE, and the partial byte is discarded. There is no GAP guarantee after a reset.
- Reset values: sck_pad 0, csn_pad 1, mosi_pad 0, busy 0, rx_valid 0, rx_data 0.

## Timing
Cycle t is the cycle in which start is sampled high with busy=0. Let D = CLK_DIV and N = BYTE_W.
- t+1: busy=1, csn_pad=0, mosi_pad = tx_data[N-1].
- SCK edge k, for k = 0..N-1:
  - Rising edge at t+1+D*(2k+1). MISO is captured on this m_clk edge.
  - Falling edge at t+1+D*(2k+2). MOSI changes on this edge.
- Last falling edge at t+1+2ND: rx_valid=1 and rx_data is updated in that same cycle.
- Without hold_cs:
  - csn_pad=1 at t+1+D*(2N+1).
  - busy=0 at t+1+D*(2N+2).
  - Next start is earliest at t+1+D*(2N+2).
- With hold_cs: busy=0 at t+1+D*(2N+1) and csn_pad stays 0.
- cs_release at cycle r: csn_pad=1 at r+1, busy=1 from r+1 through r+D, busy=0 at r+D+1.
- MISO setup margin: the peripheral changes MISO on the SCK falling edge; this controller samples D m_clk cycles later.

## Structure
- Shared package spi_pkg holds:
  - the state enum (IDLE, SETUP, XFER, TRAIL, GAP);
  - SPI_CPOL=0 and SPI_CPHA=0 constants;
  - the default BYTE_W.
- One sub-module, spi_sck_tick: a half-period counter with a restart input. It outputs a one-cycle tick every CLK_DIV cycles. The top level toggles SCK and decides rise/fall on each tick.

## Test plan
All scenarios use CLK_DIV=2, BYTE_W=8.
- Loopback (miso_pad tied to mosi_pad): start at cycle 0 with tx_data=0xA5 -> csn_pad low at 1, first SCK rise at 3, rx_valid at 33 with rx_data=0xA5, csn_pad high at 35, busy low at 37.
- Mode-0 peripheral model returning 0x3C while receiving: tx_data=0xC3 -> peripheral captures 0xC3, controller reports rx_data=0x3C, exactly 8 SCK pulses, SCK=0 whenever CSn is high.
- Burst: start 0x11 with hold_cs=1, then start 0x22 with hold_cs=0 as soon as busy falls -> CSn stays low across both bytes, two rx_valid pulses, one CSn rising edge.
- Held CSn with start and cs_release in the same cycle -> the transfer runs and the release is ignored. A later lone cs_release -> csn_pad=1 next cycle, busy low 2 cycles after that.
- start asserted again while busy -> no effect on SCK count or rx_valid count.
- rst_n=0 at cycle 15, mid-byte -> next cycle sck_pad=0, csn_pad=1, mosi_pad=0, busy=0, rx_data=0, no rx_valid pulse. A fresh start completes normally.
